// File: rtl/turfio_bus_master.sv
// turfio_bus_master
// TURFIO-side initiator for the 8-bit TURF register bus. A request
// (address, write flag, 32-bit data) becomes one bus transaction:
//   write: address cycle (nCSTURF low), then 4 data bytes LSB first
//   read : address cycle with TURF_WnR low, then 4 bytes captured from the
//          TURF, LSB first, assembled into rdata_o
// Every pin output and the DIO output enable come straight from flops so they
// can be packed into IOBs; DIO is sampled by a single posedge flop (din_q).
//
// Parameters:
//   IDLE_GAP    extra ready_o-low cycles after each transaction
//   RST_HOLDOFF ready_o-low cycles after reset so a TURF read in flight drains
//
// Ports:
//   clk_i     bus clock shared with the TURF
//   rst_i     synchronous active-high reset
//   req_i     request, accepted on an edge where req_i && ready_o
//   wr_i      1 = write, 0 = read (latched at accept)
//   addr_i    bus address byte (latched at accept)
//   wdata_i   write data (latched at accept)
//   ready_o   idle and able to accept
//   done_o    one-cycle completion pulse
//   rdata_o   last read data, held until the next read completes
//   nCSTURF   chip select, active low, single-cycle pulse
//   TURF_WnR  1 = write/idle, 0 = read
//   TURF_DIO  bidirectional data bus
//   debug_o   (only with TURFIO_BUS_MASTER_DEBUG_EN) pin snapshot one cycle late
//
// Optional feature macro: TURFIO_BUS_MASTER_DEBUG_EN
module turfio_bus_master #(
  parameter int unsigned IDLE_GAP    = 0,
  parameter int unsigned RST_HOLDOFF = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        nCSTURF,
  output logic        TURF_WnR,
  inout  wire  [7:0]  TURF_DIO
`ifdef TURFIO_BUS_MASTER_DEBUG_EN
  ,
  output logic [15:0] debug_o
`endif
);

  typedef enum logic [3:0] {
    S_HOLD, S_IDLE,
    S_WA, S_WD0, S_WD1, S_WD2, S_WD3,
    S_RA, S_RT, S_RB0, S_RB1, S_RB2, S_RB3,
    S_GAP
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [7:0]  dio_out;
  logic        dio_oe;
  logic [7:0]  din_q;
  logic [31:0] wdata_q;
  logic [23:0] rbuf;

  assign TURF_DIO = dio_oe ? dio_out : 8'bz;

  // Input flop for the bus; the TURF launches each byte mid-cycle so this
  // captures it cleanly on the following rising edge.
  always_ff @(posedge clk_i) begin
    din_q <= TURF_DIO;
  end

  // Transaction sequencer. Pin values are computed for the cycle being
  // entered, so the state name always matches what is on the pins.
  // The cycle after the last data byte (write) or the rdata capture (read)
  // is the bus turnaround; it is the first GAP cycle, or already IDLE when
  // IDLE_GAP is zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_HOLD;
      cnt      <= '0;
      ready_o  <= 1'b0;
      done_o   <= 1'b0;
      rdata_o  <= '0;
      nCSTURF  <= 1'b1;
      TURF_WnR <= 1'b1;
      dio_oe   <= 1'b0;
      dio_out  <= '0;
      wdata_q  <= '0;
      rbuf     <= '0;
    end else begin
      done_o  <= 1'b0;
      // chip select drops for exactly one cycle; a longer low retriggers the TURF
      nCSTURF <= 1'b1;
      case (state)
        S_HOLD: begin
          if (cnt + 32'd1 >= RST_HOLDOFF) begin
            state   <= S_IDLE;
            ready_o <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_IDLE: begin
          if (req_i) begin
            ready_o  <= 1'b0;
            nCSTURF  <= 1'b0;
            TURF_WnR <= wr_i;
            dio_out  <= addr_i;
            dio_oe   <= 1'b1;
            wdata_q  <= wdata_i;
            state    <= wr_i ? S_WA : S_RA;
          end
        end
        S_WA: begin
          dio_out <= wdata_q[7:0];
          state   <= S_WD0;
        end
        S_WD0: begin
          dio_out <= wdata_q[15:8];
          state   <= S_WD1;
        end
        S_WD1: begin
          dio_out <= wdata_q[23:16];
          state   <= S_WD2;
        end
        S_WD2: begin
          dio_out <= wdata_q[31:24];
          state   <= S_WD3;
        end
        S_WD3: begin
          dio_oe <= 1'b0;
          done_o <= 1'b1;
          if (IDLE_GAP == 0) begin
            state   <= S_IDLE;
            ready_o <= 1'b1;
          end else begin
            state <= S_GAP;
            cnt   <= '0;
          end
        end
        S_RA: begin
          // release the bus right after the address; the TURF owns it next
          dio_oe <= 1'b0;
          state  <= S_RT;
        end
        S_RT: state <= S_RB0;
        // din_q in RBk holds byte k launched by the TURF half a cycle earlier
        S_RB0: begin
          rbuf[7:0] <= din_q;
          state     <= S_RB1;
        end
        S_RB1: begin
          rbuf[15:8] <= din_q;
          state      <= S_RB2;
        end
        S_RB2: begin
          rbuf[23:16] <= din_q;
          state       <= S_RB3;
        end
        S_RB3: begin
          rdata_o  <= {din_q, rbuf};
          TURF_WnR <= 1'b1;
          done_o   <= 1'b1;
          if (IDLE_GAP == 0) begin
            state   <= S_IDLE;
            ready_o <= 1'b1;
          end else begin
            state <= S_GAP;
            cnt   <= '0;
          end
        end
        S_GAP: begin
          if (cnt + 32'd1 >= IDLE_GAP) begin
            state   <= S_IDLE;
            ready_o <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state   <= S_HOLD;
          cnt     <= '0;
          ready_o <= 1'b0;
          dio_oe  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TURFIO_BUS_MASTER_DEBUG_EN
  // Snapshot of the pins one cycle late; the DIO byte shows what is really
  // on the bus, i.e. the sampled input whenever the master is not driving.
  always_ff @(posedge clk_i) begin
    debug_o <= {done_o, 4'(state), dio_oe, TURF_WnR, nCSTURF,
                dio_oe ? dio_out : din_q};
  end
`endif

endmodule

// File: tb/tb_turfio_bus_master.sv
// tb_turfio_bus_master
// Directed bench for turfio_bus_master built with IDLE_GAP=2, RST_HOLDOFF=6.
// A cycle-accurate TURF read responder answers reads from a per-address table.
// When the master must have released DIO and the responder is idle, the bench
// briefly drives 0x00 onto the line: any leftover master drive then shows up
// as a non-zero (or unknown) byte.
module tb_turfio_bus_master;

  localparam int unsigned GAP     = 2;
  localparam int unsigned HOLDOFF = 6;

  localparam logic [1:0] D_DRV  = 2'd0;
  localparam logic [1:0] D_REL  = 2'd1;
  localparam logic [1:0] D_RESP = 2'd2;

  typedef struct {
    logic        req;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        e_ncs;
    logic        e_wnr;
    logic        e_rdy;
    logic        e_done;
    logic [1:0]  dmode;
    logic [7:0]  e_dio;
    logic [31:0] e_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        ncs;
  logic        wnr;
  wire  [7:0]  dio;

  logic        resp_oe  = 1'b0;
  logic [7:0]  resp_byte = 8'h00;
  logic        probe_oe = 1'b0;
  logic [31:0] resp_mem [256];
  logic [31:0] resp_word;
  int          resp_ph = 0;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  vec_t vecs [17];

  assign dio = resp_oe ? resp_byte : (probe_oe ? 8'h00 : 8'hzz);

  turfio_bus_master #(.IDLE_GAP(GAP), .RST_HOLDOFF(HOLDOFF)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .wr_i     (wr),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .ready_o  (ready),
    .done_o   (done),
    .rdata_o  (rdata),
    .nCSTURF  (ncs),
    .TURF_WnR (wnr),
    .TURF_DIO (dio)
  );

  // 10 ns bus clock
  always #5 clk = ~clk;

  // Cycle counter used to measure address-cycle spacing
  always @(posedge clk) cyc <= cyc + 1;

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string what, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_total++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", what, actual, expected);
    end
  endtask

  // TURF read responder: sees the read address cycle at the falling edge of
  // M0, then launches byte k at the falling edge of M(k+1) and releases the
  // bus at the falling edge of M5. Each launched byte is read back off the
  // pins to confirm nobody else is driving.
  always @(negedge clk) begin
    if (resp_ph == 0) begin
      if (ncs === 1'b0 && wnr === 1'b0) begin
        resp_word = resp_mem[dio];
        resp_ph   = 1;
      end
    end else if (resp_ph <= 4) begin
      resp_byte = resp_word[8*(resp_ph-1) +: 8];
      resp_oe   = 1'b1;
      resp_ph++;
      #1;
      checkOutput("resp bus readback", 32'(dio), 32'(resp_byte));
    end else begin
      resp_oe = 1'b0;
      resp_ph = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probeReleased(input string what);
    probe_oe = 1'b1;
    #1;
    checkOutput(what, 32'(dio), 32'h0);
    probe_oe = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    req   = v.req;
    wr    = v.wr;
    addr  = v.addr;
    wdata = v.wdata;
    tick();
  endtask

  task automatic waitNcsLow(output int t_seen, output logic ok);
    ok     = 1'b0;
    t_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ncs == 1'b0) begin
        ok     = 1'b1;
        t_seen = cyc;
        break;
      end
    end
  endtask

  task automatic waitReady(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready == 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic waitDone(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Counts the ready-low cycles after reset release (the release cycle
  // itself included) and notes any done pulse seen meanwhile.
  task automatic measureHoldoff(input string what);
    int   n;
    logic seen_done;
    logic ok;
    n         = 1;
    seen_done = 1'b0;
    ok        = 1'b0;
    checkOutput({what, " ready at release"}, 32'(ready), 32'h0);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) seen_done = 1'b1;
      if (ready) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    checkOutput({what, " ready returned"}, 32'(ok), 32'h1);
    checkOutput({what, " holdoff cycles"}, 32'(n), 32'(HOLDOFF));
    checkOutput({what, " no done"}, 32'(seen_done), 32'h0);
  endtask

  initial begin
    int   t0, t1, t2, n_done, ncs_low;
    logic ok;

    rst   = 1'b1;
    req   = 1'b0;
    wr    = 1'b0;
    addr  = 8'h00;
    wdata = 32'h0;
    for (int i = 0; i < 256; i++) resp_mem[i] = 32'h0;
    resp_mem[8'h00] = 32'h54555246;
    resp_mem[8'h11] = 32'hCAFE0711;
    resp_mem[8'h21] = 32'h13579BDF;
    resp_mem[8'h05] = 32'h44332211;
    resp_mem[8'hC0] = 32'hA0B1C2D3;
    resp_mem[8'hC1] = 32'h0F1E2D3C;

    // Write 0x12345678 to 0x06, then read 0x00 (responder: 46,52,55,54).
    // Rows: inputs for the edge, then expected pins in the cycle after it.
    vecs[0]  = '{1'b1, 1'b1, 8'h06, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, D_DRV,  8'h06, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 8'hFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, D_DRV,  8'h78, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 8'hFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, D_DRV,  8'h56, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 8'hFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, D_DRV,  8'h34, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 8'hFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, D_DRV,  8'h12, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 8'hFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1, D_REL,  8'h00, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 8'hFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, D_REL,  8'h00, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 8'hFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0, D_REL,  8'h00, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, D_DRV,  8'h00, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 8'hFF, 32'hAAAAAAAA, 1'b1, 1'b0, 1'b0, 1'b0, D_REL,  8'h00, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 8'hFF, 32'hAAAAAAAA, 1'b1, 1'b0, 1'b0, 1'b0, D_RESP, 8'h46, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 8'hFF, 32'hAAAAAAAA, 1'b1, 1'b0, 1'b0, 1'b0, D_RESP, 8'h52, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 8'hFF, 32'hAAAAAAAA, 1'b1, 1'b0, 1'b0, 1'b0, D_RESP, 8'h55, 32'h0};
    vecs[13] = '{1'b0, 1'b1, 8'hFF, 32'hAAAAAAAA, 1'b1, 1'b0, 1'b0, 1'b0, D_RESP, 8'h54, 32'h0};
    vecs[14] = '{1'b0, 1'b1, 8'hFF, 32'hAAAAAAAA, 1'b1, 1'b1, 1'b0, 1'b1, D_REL,  8'h00, 32'h54555246};
    vecs[15] = '{1'b0, 1'b1, 8'hFF, 32'hAAAAAAAA, 1'b1, 1'b1, 1'b0, 1'b0, D_REL,  8'h00, 32'h54555246};
    vecs[16] = '{1'b0, 1'b1, 8'hFF, 32'hAAAAAAAA, 1'b1, 1'b1, 1'b1, 1'b0, D_REL,  8'h00, 32'h54555246};

    // Reset state, with req held high to show nothing is accepted in reset
    req = 1'b1;
    wr  = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("reset ncs", 32'(ncs), 32'h1);
    checkOutput("reset wnr", 32'(wnr), 32'h1);
    checkOutput("reset ready", 32'(ready), 32'h0);
    checkOutput("reset done", 32'(done), 32'h0);
    checkOutput("reset rdata", rdata, 32'h0);
    probeReleased("reset dio released");
    req = 1'b0;
    rst = 1'b0;
    measureHoldoff("initial");

    // Table-driven write and read
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d ncs", i), 32'(ncs), 32'(vecs[i].e_ncs));
      checkOutput($sformatf("v%0d wnr", i), 32'(wnr), 32'(vecs[i].e_wnr));
      checkOutput($sformatf("v%0d ready", i), 32'(ready), 32'(vecs[i].e_rdy));
      checkOutput($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].e_done));
      checkOutput($sformatf("v%0d rdata", i), rdata, vecs[i].e_rdata);
      if (vecs[i].dmode == D_REL) begin
        probeReleased($sformatf("v%0d dio released", i));
      end else begin
        checkOutput($sformatf("v%0d dio", i), 32'(dio), 32'(vecs[i].e_dio));
      end
    end

    // req held high: write, read, write; address cycles 6+GAP then 7+GAP apart
    req   = 1'b1;
    wr    = 1'b1;
    addr  = 8'h10;
    wdata = 32'hDEADBEEF;
    tick();
    checkOutput("A first ncs", 32'(ncs), 32'h0);
    t0   = cyc;
    wr   = 1'b0;
    addr = 8'h11;
    waitNcsLow(t1, ok);
    checkOutput("A read ncs seen", 32'(ok), 32'h1);
    checkOutput("A write->read spacing", 32'(t1 - t0), 32'(6 + GAP));
    checkOutput("A read wnr", 32'(wnr), 32'h0);
    wr   = 1'b1;
    addr = 8'h12;
    waitNcsLow(t2, ok);
    checkOutput("A write ncs seen", 32'(ok), 32'h1);
    checkOutput("A read->write spacing", 32'(t2 - t1), 32'(7 + GAP));
    checkOutput("A read data", rdata, 32'hCAFE0711);
    req = 1'b0;
    waitReady(ok);
    checkOutput("A ready", 32'(ok), 32'h1);

    // Request pulsed during M2 of a read is ignored
    req  = 1'b1;
    wr   = 1'b0;
    addr = 8'h21;
    tick();
    checkOutput("B ncs M0", 32'(ncs), 32'h0);
    req = 1'b0;
    tick();
    tick();
    req  = 1'b1;
    wr   = 1'b1;
    addr = 8'h33;
    tick();
    req     = 1'b0;
    n_done  = 0;
    ncs_low = 0;
    for (int c = 4; c <= 14; c++) begin
      tick();
      if (done) begin
        n_done++;
        checkOutput("B done cycle", 32'(c), 32'd6);
      end
      if (!ncs) ncs_low++;
      checkOutput($sformatf("B rdata M%0d", c), rdata,
                  (c >= 6) ? 32'h13579BDF : 32'hCAFE0711);
    end
    checkOutput("B done count", 32'(n_done), 32'd1);
    checkOutput("B extra ncs", 32'(ncs_low), 32'd0);

    // Reset for one cycle at M3 of a read
    req  = 1'b1;
    wr   = 1'b0;
    addr = 8'h05;
    tick();
    req = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("C ncs", 32'(ncs), 32'h1);
    checkOutput("C wnr", 32'(wnr), 32'h1);
    checkOutput("C done", 32'(done), 32'h0);
    checkOutput("C rdata", rdata, 32'h0);
    checkOutput("C ready", 32'(ready), 32'h0);
    rst = 1'b0;
    measureHoldoff("C");
    resp_mem[8'h05] = 32'hF0DEBC9A;
    req  = 1'b1;
    wr   = 1'b0;
    addr = 8'h05;
    tick();
    req = 1'b0;
    waitDone(ok);
    checkOutput("C retry done", 32'(ok), 32'h1);
    checkOutput("C retry rdata", rdata, 32'hF0DEBC9A);
    waitReady(ok);
    checkOutput("C ready after", 32'(ok), 32'h1);

    // Back-to-back reads of bank 3, req held high
    req  = 1'b1;
    wr   = 1'b0;
    addr = 8'hC0;
    tick();
    checkOutput("D first ncs", 32'(ncs), 32'h0);
    addr   = 8'hC1;
    n_done = 0;
    for (int i = 0; i < 40 && n_done < 2; i++) begin
      tick();
      if (!ncs) req = 1'b0;
      if (done) begin
        n_done++;
        checkOutput($sformatf("D done%0d rdata", n_done), rdata,
                    (n_done == 1) ? 32'hA0B1C2D3 : 32'h0F1E2D3C);
      end else if (n_done == 1) begin
        checkOutput("D rdata hold", rdata, 32'hA0B1C2D3);
      end
    end
    checkOutput("D done count", 32'(n_done), 32'd2);
    req = 1'b0;
    waitReady(ok);
    checkOutput("D ready", 32'(ok), 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
